key_fetch_arbiter: RTL and testbench

KEY_FETCH_ARBITER -- requirements
Module: key_fetch_arbiter

---
 rtl/key_fetch_arbiter.sv | 149 ++++++++++++++
 tb/tb_key_fetch_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/key_fetch_arbiter.sv
// Round-robin arbiter that checks a per-requester slot policy, then reads a
// multi-beat key from the key store and returns it to the granted requester.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester per visit
// FETCH | issuing one key-store read per cycle, beat_q = beat being requested
// DRAIN | capturing the last beat returned by the key store
// RESP  | one-cycle response pulse (key or access-denied error)
module key_fetch_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_SLOTS = 4,
  parameter int KEY_WORDS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*2-1:0]          req_slot_i,
  input  logic [NUM_REQ*NUM_SLOTS-1:0]  slot_allow_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic                          rsp_err_o,
  output logic [KEY_WORDS*64-1:0]       rsp_key_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [63:0]                   mem_addr_o,
  input  logic [63:0]                   mem_rdata_i
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RESP} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         last_q;
  logic [ID_W-1:0]         id_q;
  logic [1:0]              slot_q;
  logic                    err_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [KEY_WORDS*64-1:0] key_q;
  logic                    hold_q;

  logic                    gnt_found;
  logic [ID_W-1:0]         gnt_id;
  logic [1:0]              gnt_slot;
  logic                    gnt_in_range;
  logic                    gnt_ok;
  logic                    grant_en;

  // Round-robin: first look above the last grant, then wrap to the bottom.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && (j > int'(last_q)) && req_valid_i[j]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && (j <= int'(last_q)) && req_valid_i[j]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
  end

  always_comb begin
    gnt_slot     = req_slot_i[int'(gnt_id)*2 +: 2];
    gnt_in_range = int'(gnt_slot) < NUM_SLOTS;
    gnt_ok       = gnt_in_range &&
                   slot_allow_i[int'(gnt_id)*NUM_SLOTS + (gnt_in_range ? int'(gnt_slot) : 0)];
    // No grant in the cycle right after reset so every output stays quiet.
    grant_en     = (state_q == IDLE) && !rst_i && !hold_q && gnt_found;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_en) state_d = gnt_ok ? FETCH : RESP;
      FETCH:   if (beat_q == BEAT_W'(KEY_WORDS-1)) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ-1);
      id_q    <= '0;
      slot_q  <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      key_q   <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
      if (grant_en) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        slot_q <= gnt_slot;
        err_q  <= !gnt_ok;
        beat_q <= '0;
      end
      case (state_q)
        FETCH: begin
          beat_q <= beat_q + 1'b1;
          // Read data lags its request by one cycle: capture the previous beat.
          if (beat_q != '0)
            key_q[(int'(beat_q)-1)*64 +: 64] <= mem_rdata_i;
        end
        DRAIN:   key_q[(KEY_WORDS-1)*64 +: 64] <= mem_rdata_i;
        RESP:    key_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    rsp_key_o   = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    if (!rst_i) begin
      if (grant_en)
        req_ready_o[gnt_id] = 1'b1;
      case (state_q)
        FETCH: begin
          mem_req_o  = 1'b1;
          mem_addr_o = (64'(slot_q) * 64'(KEY_WORDS) + 64'(beat_q)) << 3;
        end
        RESP: begin
          rsp_valid_o[id_q] = 1'b1;
          rsp_err_o         = err_q;
          rsp_key_o         = err_q ? '0 : key_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o = 1'b0;

endmodule

// File: tb/tb_key_fetch_arbiter.sv
// Directed bench for key_fetch_arbiter: fetch path, denial, round-robin,
// reset abort and out-of-range slot on a NUM_SLOTS=3 instance.
module tb_key_fetch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   req_valid, req_valid3;
  logic [3:0]   req_slot;
  logic [7:0]   allow;
  logic [5:0]   allow3;
  logic [63:0]  mem_rdata;

  logic [1:0]   ready, rsp_valid;
  logic         rsp_err, mem_req, mem_we;
  logic [191:0] rsp_key;
  logic [63:0]  mem_addr;

  logic [1:0]   ready3, rsp_valid3;
  logic         rsp_err3, mem_req3, mem_we3;
  logic [191:0] rsp_key3;
  logic [63:0]  mem_addr3;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] t3_rdy [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] t3_rsp [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  key_fetch_arbiter u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_slot_i(req_slot), .slot_allow_i(allow),
    .req_ready_o(ready), .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err),
    .rsp_key_o(rsp_key), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  key_fetch_arbiter #(.NUM_SLOTS(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid3), .req_slot_i(req_slot), .slot_allow_i(allow3),
    .req_ready_o(ready3), .rsp_valid_o(rsp_valid3), .rsp_err_o(rsp_err3),
    .rsp_key_o(rsp_key3), .mem_req_o(mem_req3), .mem_we_o(mem_we3),
    .mem_addr_o(mem_addr3), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [63:0] dat(input logic [63:0] a);
    return 64'hC0DE_0000_0000_0000 | a;
  endfunction

  // Key store: data tagged with its own address, one cycle after the strobe.
  always @(posedge clk) mem_rdata <= mem_req ? dat(mem_addr) : 64'h0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {ready, rsp_valid, rsp_err, mem_req, mem_we, mem_addr}, '0);
    chk({tag, "_key"}, rsp_key, '0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_valid3 = '0; req_slot = '0; allow = '0; allow3 = '0;

    cyc(); smp(); chk_zero("rst");
    cyc(); rst = 1'b0; smp(); chk_zero("post_rst");

    // permitted fetch r0 slot 2; r1 (denied, slot 0) raised mid-fetch
    cyc(); req_valid = 2'b01; req_slot = 4'b0010; allow = 8'b0000_0100;
    smp(); chk("t1_gnt", ready, 2'b01); chk("t1_gnt_mem", mem_req, 1'b0);
    for (int b = 0; b < 3; b++) begin
      cyc(); if (b == 0) req_valid = 2'b10;
      smp();
      chk($sformatf("t1_addr%0d", b), {mem_req, mem_addr}, {1'b1, 64'(48 + 8*b)});
      chk($sformatf("t1_nogrant%0d", b), {ready, rsp_valid}, '0);
    end
    cyc(); smp(); chk("t1_drain", {ready, rsp_valid, mem_req, mem_addr}, '0);
    cyc(); smp();
    chk("t1_rsp", {ready, rsp_valid, rsp_err}, {2'b00, 2'b01, 1'b0});
    chk("t1_key", rsp_key, {dat(64'h40), dat(64'h38), dat(64'h30)});
    cyc(); smp();
    chk("t2_gnt", {ready, rsp_valid}, {2'b10, 2'b00});
    chk("t1_keyclr", rsp_key, '0);
    cyc(); req_valid = '0; smp();
    chk("t2_rsp", {rsp_valid, rsp_err, mem_req}, {2'b10, 1'b1, 1'b0});
    chk("t2_key", rsp_key, '0);
    cyc(); smp(); chk_zero("t2_after");

    // both held from reset, denied -> alternating grants
    cyc(); rst = 1'b1; req_valid = 2'b11; req_slot = 4'b0101; allow = '0;
    smp(); chk_zero("t3_rst");
    cyc(); rst = 1'b0; smp(); chk_zero("t3_hold");
    for (int i = 0; i < 8; i++) begin
      cyc(); smp();
      chk($sformatf("t3_rdy%0d", i), ready, t3_rdy[i]);
      chk($sformatf("t3_rsp%0d", i), rsp_valid, t3_rsp[i]);
    end
    cyc(); req_valid = '0; smp(); chk("t3_end", ready, 2'b00);

    // reset during FETCH aborts; next request completes
    cyc(); req_valid = 2'b01; req_slot = 4'b0001; allow = 8'b0000_0010;
    smp(); chk("t4_gnt", ready, 2'b01);
    cyc(); req_valid = '0; smp(); chk("t4_addr0", {mem_req, mem_addr}, {1'b1, 64'h18});
    cyc(); rst = 1'b1; smp(); chk_zero("t4_rst");
    cyc(); rst = 1'b0; smp(); chk_zero("t4_hold");
    for (int i = 0; i < 5; i++) begin
      cyc(); smp(); chk($sformatf("t4_norsp%0d", i), {rsp_valid, mem_req}, '0);
    end
    cyc(); req_valid = 2'b10; req_slot = 4'b1100; allow = 8'b1000_0000;
    smp(); chk("t4b_gnt", ready, 2'b10);
    cyc(); req_valid = 2'b01; smp(); chk("t4b_addr0", {ready, mem_req, mem_addr}, {2'b00, 1'b1, 64'h48});
    cyc(); req_valid = '0;    smp(); chk("t4b_addr1", {mem_req, mem_addr}, {1'b1, 64'h50});
    cyc(); smp(); chk("t4b_addr2", {mem_req, mem_addr}, {1'b1, 64'h58});
    cyc(); smp(); chk("t4b_drain", {mem_req, rsp_valid}, '0);
    cyc(); smp();
    chk("t4b_rsp", {rsp_valid, rsp_err}, {2'b10, 1'b0});
    chk("t4b_key", rsp_key, {dat(64'h58), dat(64'h50), dat(64'h48)});
    cyc(); smp(); chk("t4b_nodrop", {ready, rsp_valid}, '0); chk("t4b_keyclr", rsp_key, '0);
    cyc(); smp(); chk("t4b_nodrop2", ready, 2'b00);

    // slot 3 on a 3-slot store is denied regardless of policy
    cyc(); req_valid3 = 2'b01; req_slot = 4'b0011; allow3 = 6'b111111;
    smp(); chk("t5_gnt", {ready3, mem_req3}, {2'b01, 1'b0});
    cyc(); req_valid3 = '0; smp();
    chk("t5_rsp", {rsp_valid3, rsp_err3, mem_req3, mem_we3}, {2'b01, 1'b1, 1'b0, 1'b0});
    chk("t5_key", rsp_key3, '0);
    cyc(); smp(); chk("t5_after", {rsp_valid3, rsp_err3, mem_addr3}, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
